lcd_spi_tx: RTL and testbench

LCD_SPI_TX -- requirements
Module: lcd_spi_tx

---
 rtl/lcd_spi_tx.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_spi_tx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for an LCD controller with chip select and D/C line.
// Define LCD_SPI_TX_FIFO_EN for a 4-entry input FIFO; otherwise a single holding register is used.
module lcd_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_dc,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       done,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  output logic       dc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] gap_q, gap_d;
  logic [6:0] shreg_q, shreg_d;
  logic       ss_q, ss_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       dc_q, dc_d;
  logic       done_q, done_d;

  logic       push;
  logic       pop;
  logic       buf_empty;
  logic       buf_full;
  logic [8:0] buf_head;

  // Readiness depends only on occupancy, so a pop in the same cycle never frees a slot early.
  assign in_ready = rst | ~buf_full;
  assign push     = in_valid & ~buf_full & ~rst;
  assign pop      = (state_q == IDLE) & ~buf_empty;
  assign busy     = ~rst & ((state_q != IDLE) | ~buf_empty);

`ifdef LCD_SPI_TX_FIFO_EN
  logic [8:0] mem_q [4];
  logic [8:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  assign buf_empty = (count_q == 3'd0);
  assign buf_full  = (count_q == 3'd4);
  assign buf_head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_dc, in_data};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end
`else
  logic [8:0] hold_q, hold_d;
  logic       full_q, full_d;

  assign buf_empty = ~full_q;
  assign buf_full  = full_q;
  assign buf_head  = hold_q;

  // A push can only happen while empty, so push and pop never collide here.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push) begin
      hold_d = {in_dc, in_data};
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
    hold_q <= hold_d;
  end
`endif

  // Outputs are registered: the cycle after the pop is byte cycle 0, and every
  // sck edge lands on a multiple of CLK_DIV counted from there.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!buf_empty) begin
          state_d = SHIFT;
          ss_d    = 1'b0;
          sck_d   = 1'b0;
          dc_d    = buf_head[8];
          mosi_d  = buf_head[7];
          shreg_d = buf_head[6:0];
          div_d   = 8'd0;
          bit_d   = 3'd0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q == 3'd7) begin
            state_d = GAP;
            ss_d    = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            gap_d   = 8'd0;
          end else begin
            sck_d   = 1'b0;
            bit_d   = bit_q + 3'd1;
            mosi_d  = shreg_q[6];
            shreg_d = {shreg_q[5:0], 1'b0};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      gap_q   <= 8'd0;
      shreg_q <= 7'd0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
    end
  end

  assign ss   = ss_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign dc   = dc_q;
  assign done = done_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Directed self-checking bench for lcd_spi_tx (CLK_DIV=2, GAP_CYCLES=2).
// Works with or without LCD_SPI_TX_FIFO_EN defined.
module tb_lcd_spi_tx;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 2;
`ifdef LCD_SPI_TX_FIFO_EN
  localparam int EXP_EARLY_ACCEPTS = 5;
`else
  localparam int EXP_EARLY_ACCEPTS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_dc = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, busy, done, ss, sck, mosi, dc;

  int checks = 0;
  int failures = 0;

  // Receiver-side observations collected by the line monitor below
  int rxQ[$], lowQ[$], highQ[$], doneAtQ[$], dcStartQ[$], dcBeforeQ[$];
  int mosiErr = 0, sckErr = 0, dcErr = 0;
  logic prevSs = 1'b1, prevSck = 1'b0, prevMosi = 1'b0, prevDc = 1'b0;
  logic seenByte = 1'b0;
  int cyc = 0, lowLen = 0, highLen = 0;
  logic [7:0] shiftIn = 8'h00;

  logic [7:0] burst [6];
  logic       readyHist [0:799];

  lcd_spi_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_dc   (in_dc),
    .in_data (in_data),
    .busy    (busy),
    .done    (done),
    .ss      (ss),
    .sck     (sck),
    .mosi    (mosi),
    .dc      (dc)
  );

  always #5 clk = ~clk;

  // Watch the LCD-side pins like a real slave would: shift mosi in on sck rising
  // edges, measure ss low/high lengths, and flag protocol timing violations.
  always @(negedge clk) begin
    if (ss === 1'b0) begin
      if (prevSs !== 1'b0) begin
        cyc = 0;
        lowLen = 0;
        shiftIn = 8'h00;
        dcStartQ.push_back(int'(dc));
        dcBeforeQ.push_back(int'(prevDc));
        if (seenByte) highQ.push_back(highLen);
      end else begin
        cyc++;
        if (dc !== prevDc) dcErr++;
        if (mosi !== prevMosi && !(prevSck === 1'b1 && sck === 1'b0)) mosiErr++;
      end
      lowLen++;
      if (sck === 1'b1 && prevSck === 1'b0) begin
        shiftIn = {shiftIn[6:0], mosi};
        if (cyc % (2 * CLK_DIV) != CLK_DIV) sckErr++;
      end
      if (sck === 1'b0 && prevSck === 1'b1 && cyc % (2 * CLK_DIV) != 0) sckErr++;
    end else begin
      if (prevSs === 1'b0) begin
        rxQ.push_back(int'(shiftIn));
        lowQ.push_back(lowLen);
        seenByte = 1'b1;
        highLen = 0;
      end
      cyc++;
      highLen++;
      if (ss === 1'b1 && mosi !== 1'b0) mosiErr++;
      if (ss === 1'b1 && sck !== 1'b0) sckErr++;
    end
    if (done === 1'b1) doneAtQ.push_back(cyc);
    prevSs = ss;
    prevSck = sck;
    prevMosi = mosi;
    prevDc = dc;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qAt(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  // Offer one byte and hold it until the DUT takes it
  task automatic applyStimulus(input logic d, input logic [7:0] b);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_dc = d;
    in_data = b;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic clearMonitor();
    @(posedge clk);
    rxQ.delete();
    lowQ.delete();
    highQ.delete();
    doneAtQ.delete();
    dcStartQ.delete();
    dcBeforeQ.delete();
    seenByte = 1'b0;
  endtask

  task automatic waitBytes(input int n);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (rxQ.size() >= n) break;
    end
    checkOutput("wait_bytes", rxQ.size(), n);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic waitIdle();
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && ss === 1'b1) begin
        ok = 1;
        break;
      end
    end
    checkOutput("wait_idle", ok, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted, early, nthAcc, firstDone, readyRise, idx;
    int doneSeen, ssLowSeen, busySeen;
    logic nthNext;

    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;

    // Reset: outputs at reset values, a transfer offered during reset is dropped
    in_valid = 1'b1;
    in_dc = 1'b1;
    in_data = 8'h55;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ss", ss, 1);
    checkOutput("rst_sck", sck, 0);
    checkOutput("rst_mosi", mosi, 0);
    checkOutput("rst_dc", dc, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_discard_busy", busy, 0);
    repeat (20) @(negedge clk);
    checkOutput("rst_discard_no_byte", rxQ.size(), 0);

    // Command byte 0x21: 32 cycles of ss low, MSB first, done at byte cycle 32
    clearMonitor();
    applyStimulus(1'b0, 8'h21);
    waitBytes(1);
    checkOutput("b21_data", qAt(rxQ, 0), 32'h21);
    checkOutput("b21_ss_low", qAt(lowQ, 0), 32);
    checkOutput("b21_done_count", doneAtQ.size(), 1);
    checkOutput("b21_done_cycle", qAt(doneAtQ, 0), 32);
    checkOutput("b21_dc", qAt(dcStartQ, 0), 0);
    waitIdle();

    // Back-to-back data bytes: gap of GAP_CYCLES+1 ss-high cycles
    clearMonitor();
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b1, 8'h3C);
    waitBytes(2);
    checkOutput("b2b_first", qAt(rxQ, 0), 32'hA5);
    checkOutput("b2b_second", qAt(rxQ, 1), 32'h3C);
    checkOutput("b2b_gap", qAt(highQ, 0), GAP_CYCLES + 1);
    checkOutput("b2b_done_count", doneAtQ.size(), 2);
    checkOutput("b2b_dc", qAt(dcStartQ, 1), 1);
    waitIdle();

    // Command then data: dc switches exactly at cycle 0 of each byte
    clearMonitor();
    applyStimulus(1'b0, 8'h21);
    applyStimulus(1'b1, 8'hAA);
    waitBytes(2);
    checkOutput("dc_cmd_data", qAt(rxQ, 1), 32'hAA);
    checkOutput("dc_byte1_start", qAt(dcStartQ, 0), 0);
    checkOutput("dc_byte1_before", qAt(dcBeforeQ, 0), 1);
    checkOutput("dc_byte2_start", qAt(dcStartQ, 1), 1);
    checkOutput("dc_byte2_before", qAt(dcBeforeQ, 1), 0);
    waitIdle();

    // Reset at byte cycle 10 of 0xFF with a second byte buffered
    clearMonitor();
    applyStimulus(1'b1, 8'hFF);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ss === 1'b0) break;
    end
    checkOutput("abort_started", ss, 0);
    checkOutput("abort_second_ready", in_ready, 1);
    in_valid = 1'b1;
    in_dc = 1'b0;
    in_data = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("abort_pre_sck", sck, 1);
    checkOutput("abort_pre_mosi", mosi, 1);
    checkOutput("abort_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ss", ss, 1);
    checkOutput("abort_sck", sck, 0);
    checkOutput("abort_mosi", mosi, 0);
    checkOutput("abort_dc", dc, 0);
    checkOutput("abort_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    doneSeen = 0;
    ssLowSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0) doneSeen++;
      if (ss !== 1'b1) ssLowSeen++;
      if (busy !== 1'b0) busySeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    checkOutput("abort_flushed_ss", ssLowSeen, 0);
    checkOutput("abort_flushed_busy", busySeen, 0);
    clearMonitor();
    applyStimulus(1'b1, 8'h5A);
    waitBytes(1);
    checkOutput("abort_next_data", qAt(rxQ, 0), 32'h5A);
    checkOutput("abort_next_len", qAt(lowQ, 0), 32);
    waitIdle();

    // Burst of 6 with in_valid held from reset release: buffer depth shows up
    // as the number of bytes taken before the first byte finishes
    clearMonitor();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_dc = 1'b1;
    in_data = burst[0];
    idx = 0;
    accepted = 0;
    early = 0;
    nthAcc = -1;
    firstDone = -1;
    readyRise = -1;
    for (int c = 0; c < 800 && idx < 6; c++) begin
      @(negedge clk);
      readyHist[c] = in_ready;
      if (done === 1'b1 && firstDone < 0) firstDone = c;
      if (firstDone >= 0 && readyRise < 0 && c > firstDone && in_ready === 1'b1) readyRise = c;
      if (in_ready === 1'b1) begin
        accepted++;
        if (firstDone < 0) begin
          early++;
          if (early == EXP_EARLY_ACCEPTS) nthAcc = c;
        end
        @(posedge clk); #1;
        idx++;
        if (idx < 6) in_data = burst[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    nthNext = (nthAcc >= 0 && nthAcc < 799) ? readyHist[nthAcc + 1] : 1'bx;
    checkOutput("burst_early_accepts", early, EXP_EARLY_ACCEPTS);
    checkOutput("burst_ready_low_after", nthNext, 0);
    checkOutput("burst_first_done", firstDone, 34);
    checkOutput("burst_ready_rise", readyRise, firstDone + 3);
    checkOutput("burst_total_accepts", accepted, 6);
    waitBytes(6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("burst_byte%0d", i), qAt(rxQ, i), int'(burst[i]));
    end
    checkOutput("burst_done_count", doneAtQ.size(), 6);
    waitIdle();

    // Protocol timing accumulated across the whole run
    checkOutput("mosi_timing", mosiErr, 0);
    checkOutput("sck_timing", sckErr, 0);
    checkOutput("dc_midbyte", dcErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
